dsm_bitstream_modulator: RTL and testbench

Digital second-order delta-sigma modulator that produces the 1-bit oversampled stream our decimation filter consumes. It accepts one multi-bit sample per frame of M clocks over a valid/ready handshake and emits one bit per clock, with a frame_start marker. Mode 0 (incremental) clears the integrators every frame, so the stream can be decoded frame-by-frame. Mode 1 (regular) runs the loop continuously. It is used as an on-chip stimulus source and as a loopback partner for the decimation filter.

---
 rtl/dsm_bitstream_modulator_if.sv | 22 ++
 rtl/dsm_bitstream_modulator.sv | 142 ++++++++++++++
 tb/tb_dsm_bitstream_modulator.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dsm_bitstream_modulator_if.sv
// Sample handshake and bitstream bundle for the second-order delta-sigma modulator.
interface dsm_bitstream_modulator_if #(
   parameter int IN_BITS = 12
);
   logic [IN_BITS-1:0] din;
   logic               din_valid;
   logic               din_ready;
   logic               bit_out;
   logic               bit_valid;
   logic               frame_start;
   logic               overload;

   modport master (
      output din, din_valid,
      input  din_ready, bit_out, bit_valid, frame_start, overload
   );

   modport slave (
      input  din, din_valid,
      output din_ready, bit_out, bit_valid, frame_start, overload
   );
endinterface

// File: rtl/dsm_bitstream_modulator.sv
// Second-order delta-sigma modulator: one sample per M-clock frame in, one bit per clock out.
// Mode 0 clears both integrators at every frame boundary; mode 1 runs the loop continuously.
module dsm_bitstream_modulator #(
   parameter int IN_BITS  = 12,
   parameter int M        = 16,
   parameter int ACC_BITS = IN_BITS + 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic mode,
   dsm_bitstream_modulator_if.slave dsm
);
   localparam int CNT_BITS = $clog2(M);
   // Three guard bits cover i2 + i1 - 2*fb before clamping.
   localparam int WIDE     = ACC_BITS + 3;
   localparam logic signed [WIDE-1:0]     H_W       = WIDE'(2 ** (IN_BITS - 1));
   localparam logic signed [WIDE-1:0]     ACC_MAX_W = WIDE'(2 ** (ACC_BITS - 1) - 1);
   localparam logic signed [ACC_BITS-1:0] ACC_MAX   = ACC_BITS'(2 ** (ACC_BITS - 1) - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                     state, state_nxt;
   logic [CNT_BITS-1:0]        cnt;
   logic [IN_BITS-1:0]         din_hold;
   logic signed [ACC_BITS-1:0] i1, i2, i1_nxt, i2_nxt;
   logic signed [WIDE-1:0]     i1_w, i2_w, x_w, fb_w, i1_sum, i2_sum;
   logic                       mode_d, mode_chg, last, v, clamp1, clamp2, din_ready_c;
   logic                       bit_out_r, bit_valid_r, frame_start_r, overload_r;

   assign mode_chg = (mode != mode_d);
   assign last     = (cnt == CNT_BITS'(M - 1));

   always_comb begin
      state_nxt   = state;
      din_ready_c = 1'b0;
      case (state)
         IDLE: begin
            din_ready_c = enable;
            if (dsm.din_valid && enable) state_nxt = RUN;
         end
         RUN: din_ready_c = enable && last;
         default: state_nxt = IDLE;
      endcase
      if (mode_chg) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      i1_w   = WIDE'(i1);
      i2_w   = WIDE'(i2);
      x_w    = $signed({{(WIDE - IN_BITS){1'b0}}, din_hold}) - H_W;
      v      = ~i2[ACC_BITS-1];
      fb_w   = v ? H_W : -H_W;
      i1_sum = i1_w + x_w - fb_w;
      i2_sum = i2_w + i1_w - (fb_w <<< 1);
      clamp1 = 1'b0;
      clamp2 = 1'b0;
      i1_nxt = i1_sum[ACC_BITS-1:0];
      i2_nxt = i2_sum[ACC_BITS-1:0];
      if (i1_sum > ACC_MAX_W) begin
         i1_nxt = ACC_MAX;
         clamp1 = 1'b1;
      end else if (i1_sum < -ACC_MAX_W) begin
         i1_nxt = -ACC_MAX;
         clamp1 = 1'b1;
      end
      if (i2_sum > ACC_MAX_W) begin
         i2_nxt = ACC_MAX;
         clamp2 = 1'b1;
      end else if (i2_sum < -ACC_MAX_W) begin
         i2_nxt = -ACC_MAX;
         clamp2 = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_d        <= mode;
         cnt           <= '0;
         din_hold      <= '0;
         i1            <= '0;
         i2            <= '0;
         bit_out_r     <= 1'b0;
         bit_valid_r   <= 1'b0;
         frame_start_r <= 1'b0;
         overload_r    <= 1'b0;
      end else begin
         mode_d <= mode;
         if (mode_chg) begin
            cnt           <= '0;
            din_hold      <= '0;
            i1            <= '0;
            i2            <= '0;
            bit_out_r     <= 1'b0;
            bit_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            overload_r    <= 1'b0;
         end else if (state == IDLE) begin
            bit_out_r     <= 1'b0;
            bit_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            overload_r    <= 1'b0;
            if (dsm.din_valid && din_ready_c) begin
               din_hold <= dsm.din;
               i1       <= '0;
               i2       <= '0;
               cnt      <= '0;
            end
         end else if (!enable) begin
            bit_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            overload_r    <= 1'b0;
         end else begin
            bit_out_r     <= v;
            bit_valid_r   <= 1'b1;
            frame_start_r <= (cnt == '0);
            overload_r    <= clamp1 | clamp2;
            cnt           <= cnt + CNT_BITS'(1);
            // Incremental mode discards the updated integrators so the next frame starts from zero.
            if (last && !mode) begin
               i1 <= '0;
               i2 <= '0;
            end else begin
               i1 <= i1_nxt;
               i2 <= i2_nxt;
            end
            if (last && dsm.din_valid) din_hold <= dsm.din;
         end
      end
   end

   assign dsm.din_ready   = din_ready_c;
   assign dsm.bit_out     = bit_out_r;
   assign dsm.bit_valid   = bit_valid_r;
   assign dsm.frame_start = frame_start_r;
   assign dsm.overload    = overload_r;
endmodule

// File: tb/tb_dsm_bitstream_modulator.sv
// Bench for dsm_bitstream_modulator: directed scenarios plus random traffic against an integer loop model.
module tb_dsm_bitstream_modulator;
   localparam int IN_BITS  = 12;
   localparam int M        = 16;
   localparam int ACC_BITS = IN_BITS + 4;
   localparam int H        = 2 ** (IN_BITS - 1);
   localparam int LIM      = 2 ** (ACC_BITS - 1) - 1;

   logic clk = 1'b0;
   logic reset, enable, mode;
   int   checks = 0;
   int   errors = 0;

   dsm_bitstream_modulator_if #(.IN_BITS(IN_BITS)) dif ();

   dsm_bitstream_modulator #(.IN_BITS(IN_BITS), .M(M), .ACC_BITS(ACC_BITS)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .mode   (mode),
      .dsm    (dif.slave)
   );

   always #5 clk = ~clk;

   // Behavioural loop state in plain integers.
   bit m_run, m_mode_d, m_bit, m_bv, m_fs, m_ov, last_take;
   int m_cnt, m_hold, m_i1, m_i2;
   bit obs_bits[$];
   int fones[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clampv(input int val, output bit hit);
      hit = (val > LIM) || (val < -LIM);
      return (val > LIM) ? LIM : ((val < -LIM) ? -LIM : val);
   endfunction

   task automatic model_clear();
      m_run = 0; m_cnt = 0; m_hold = 0; m_i1 = 0; m_i2 = 0;
      m_bit = 0; m_bv = 0; m_fs = 0; m_ov = 0;
   endtask

   task automatic model_step();
      int x, fb, n1, n2;
      bit c1, c2;
      if (mode != m_mode_d) begin
         model_clear();
      end else if (!m_run) begin
         m_bit = 0; m_bv = 0; m_fs = 0; m_ov = 0;
         if (dif.din_valid && enable) begin
            m_run = 1; m_hold = int'(dif.din); m_i1 = 0; m_i2 = 0; m_cnt = 0;
         end
      end else if (!enable) begin
         m_bv = 0; m_fs = 0; m_ov = 0;
      end else begin
         x  = m_hold - H;
         fb = (m_i2 >= 0) ? H : -H;
         n1 = clampv(m_i1 + x - fb, c1);
         n2 = clampv(m_i2 + m_i1 - 2 * fb, c2);
         m_bit = (m_i2 >= 0);
         m_bv  = 1;
         m_fs  = (m_cnt == 0);
         m_ov  = c1 | c2;
         if (m_cnt == M - 1) begin
            if (mode == 1'b0) begin n1 = 0; n2 = 0; end
            if (dif.din_valid) m_hold = int'(dif.din);
         end
         m_i1  = n1;
         m_i2  = n2;
         m_cnt = (m_cnt + 1) % M;
      end
      m_mode_d = mode;
   endtask

   task automatic cycle();
      bit er;
      #1;
      er = m_run ? (enable && m_cnt == M - 1) : enable;
      check("din_ready", dif.din_ready, er);
      last_take = dif.din_valid && er && (mode == m_mode_d);
      @(posedge clk);
      model_step();
      #1;
      check("bit_valid", dif.bit_valid, m_bv);
      check("bit_out", dif.bit_out, m_bit);
      check("frame_start", dif.frame_start, m_fs);
      check("overload", dif.overload, m_ov);
      if (dif.bit_valid === 1'b1) begin
         obs_bits.push_back(dif.bit_out);
         if (dif.frame_start === 1'b1) fones.push_back(0);
         if (fones.size() > 0) fones[fones.size() - 1] += int'(dif.bit_out);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_clear();
      m_mode_d = mode;
      check("rst_bit_valid", dif.bit_valid, 1'b0);
      check("rst_bit_out", dif.bit_out, 1'b0);
      check("rst_frame_start", dif.frame_start, 1'b0);
      check("rst_overload", dif.overload, 1'b0);
      check("rst_din_ready", dif.din_ready, enable);
      reset = 1'b0;
   endtask

   function automatic logic [31:0] pack_bits(input int first, input int n);
      logic [31:0] w = '0;
      for (int k = 0; k < n; k++) w = {w[30:0], obs_bits[first + k]};
      return w;
   endfunction

   initial begin
      int bad;
      logic [31:0] p32;
      reset = 1'b0; enable = 1'b0; mode = 1'b1;
      dif.din = '0; dif.din_valid = 1'b0;
      do_reset();

      // Regular mode, mid-scale input: 1,0,0,1 repeating, 8 ones per frame.
      enable = 1'b1; dif.din = 12'd2048; dif.din_valid = 1'b1;
      obs_bits.delete(); fones.delete();
      cycle();
      dif.din_valid = 1'b0;
      run(40);
      p32 = 32'h9999_9999;
      check("mid_pattern", pack_bits(0, 32), p32);
      check("mid_ones_f0", fones[0], 8);
      check("mid_ones_f1", fones[1], 8);
      // Pause mid-frame, then resume; stream must stay periodic, and a late offer is only taken at cnt=15.
      run(3);
      enable = 1'b0;
      run(5);
      enable = 1'b1;
      dif.din_valid = 1'b1;
      run(30);
      dif.din_valid = 1'b0;
      bad = 0;
      foreach (obs_bits[k]) if (obs_bits[k] !== ((k % 4 == 0) || (k % 4 == 3))) bad++;
      check("mid_resume_bad_bits", bad, 0);

      // Mode change to incremental: back to IDLE; zero input gives 1 then 15 zeros each frame.
      mode = 1'b0;
      cycle();
      check("modechg_bit_valid", dif.bit_valid, 1'b0);
      dif.din = 12'd0; dif.din_valid = 1'b1;
      obs_bits.delete(); fones.delete();
      cycle();
      dif.din_valid = 1'b0;
      run(50);
      check("zero_frame0", pack_bits(0, 16), 32'h0000_8000);
      check("zero_frame1", pack_bits(16, 16), 32'h0000_8000);
      check("zero_ones_f2", fones[2], 1);

      // Incremental mode, alternating 1024/3072 per frame with din_valid held.
      do_reset();
      dif.din = 12'd1024; dif.din_valid = 1'b1;
      obs_bits.delete(); fones.delete();
      for (int k = 0; k < 6 * M + 4; k++) begin
         cycle();
         if (last_take) dif.din = (dif.din == 12'd1024) ? 12'd3072 : 12'd1024;
      end
      dif.din_valid = 1'b0;
      check("alt_monotonic", fones[0] < fones[1], 1'b1);
      check("alt_repeat_lo", fones[2], fones[0]);
      check("alt_repeat_hi", fones[3], fones[1]);
      check("alt_repeat_lo2", fones[4], fones[0]);

      // Mode toggle mid-frame, then a fresh sample starts with a 1.
      run(5);
      mode = 1'b1;
      cycle();
      check("toggle_bit_valid", dif.bit_valid, 1'b0);
      dif.din = 12'd700; dif.din_valid = 1'b1;
      obs_bits.delete(); fones.delete();
      cycle();
      dif.din_valid = 1'b0;
      run(3);
      check("toggle_first_bit", obs_bits[0], 1'b1);
      // Reset mid-frame, then restart.
      run(6);
      do_reset();
      dif.din = 12'd3500; dif.din_valid = 1'b1;
      obs_bits.delete(); fones.delete();
      cycle();
      dif.din_valid = 1'b0;
      run(3);
      check("reset_first_bit", obs_bits[0], 1'b1);

      // Random traffic, including full-scale inputs that can drive the loop into saturation.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 59) == 0) mode = ~mode;
         enable = ($urandom_range(0, 9) != 0);
         dif.din_valid = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: dif.din = 12'd4095;
            1: dif.din = 12'd0;
            default: dif.din = IN_BITS'($urandom_range(0, 4095));
         endcase
         if ($urandom_range(0, 249) == 0) do_reset();
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
